// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS datapath definitions.
//   muldiv_op_t  - multiply/divide unit operation codes (6 and 7 are no-ops)
//   MULDIV_STATE - multiply/divide unit FSM states
//   abs_w        - two's-complement magnitude helper
package mips_pkg;

    // Widest operand abs_w can handle; callers truncate the result to their width.
    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } MULDIV_STATE;

    // Magnitude of a zero-extended value whose sign is passed separately. Negating the
    // zero-extended form yields the correct low bits, so the most negative value maps
    // to its unsigned magnitude.
    function automatic logic [MAX_WIDTH-1:0] abs_w(input logic [MAX_WIDTH-1:0] v,
                                                  input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle of the multiply/divide unit.
//   start, op, rs, rt, cancel - request side, driven by control (master)
//   hi, lo, busy, done        - architectural HI/LO and handshake, driven by the unit (slave)
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             cancel;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, rs, rt, cancel,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, rs, rt, cancel,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers, single-cycle MTHI/MTLO.
//   clk   - clock, all state changes on the rising edge
//   reset - synchronous active-high reset
//   bus   - muldiv_unit_if slave: start/op/rs/rt/cancel in, hi/lo/busy/done out
// A mult/div accepted in cycle T shows busy for WIDTH+1 cycles and delivers hi/lo with a
// one-cycle done pulse in cycle T+WIDTH+2.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    MULDIV_STATE        state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;       // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   b_q;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   rs_q;
    logic               is_div_q;
    logic               neg_q;     // sign of product / quotient
    logic               rs_neg_q;  // sign of remainder
    logic               dz_q;      // divide by zero
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    // Request decode
    logic             is_muldiv;
    logic             is_div_op;
    logic             is_signed;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;

    always_comb begin
        is_muldiv = 1'b0;
        is_div_op = 1'b0;
        is_signed = 1'b0;
        case (bus.op)
            MULT:    begin is_muldiv = 1'b1; is_signed = 1'b1; end
            MULTU:   begin is_muldiv = 1'b1; end
            DIV:     begin is_muldiv = 1'b1; is_div_op = 1'b1; is_signed = 1'b1; end
            DIVU:    begin is_muldiv = 1'b1; is_div_op = 1'b1; end
            default: ;
        endcase
        rs_mag = WIDTH'(abs_w(MAX_WIDTH'(bus.rs), is_signed & bus.rs[WIDTH-1]));
        rt_mag = WIDTH'(abs_w(MAX_WIDTH'(bus.rt), is_signed & bus.rt[WIDTH-1]));
    end

    // One shared WIDTH+1-bit adder/subtractor per iteration
    logic [WIDTH:0]     add_a;
    logic [WIDTH:0]     add_s;
    logic [2*WIDTH-1:0] acc_nxt;

    always_comb begin
        add_a = is_div_q ? {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]}
                         : {1'b0, acc[2*WIDTH-1:WIDTH]};
        add_s = is_div_q ? (add_a - {1'b0, b_q}) : (add_a + {1'b0, b_q});
        if (is_div_q) begin
            // Restoring step: keep the shifted remainder when the subtraction borrows
            acc_nxt = add_s[WIDTH] ? {add_a[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {add_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = acc[0] ? {add_s, acc[WIDTH-1:1]}
                             : {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
        end
    end

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        prod = neg_q ? (~acc + 1'b1) : acc;
        quot = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem  = rs_neg_q ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            b_q      <= '0;
            rs_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rs_neg_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // cancel in IDLE suppresses a same-cycle start
                    if (bus.start && !bus.cancel) begin
                        if (is_muldiv) begin
                            state    <= CALC;
                            busy_q   <= 1'b1;
                            cnt      <= '0;
                            is_div_q <= is_div_op;
                            neg_q    <= is_signed & (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1]);
                            rs_neg_q <= is_signed & bus.rs[WIDTH-1];
                            dz_q     <= is_div_op && (bus.rt == '0);
                            rs_q     <= bus.rs;
                            acc      <= {{WIDTH{1'b0}}, (is_div_op ? rs_mag : rt_mag)};
                            b_q      <= is_div_op ? rt_mag : rs_mag;
                        end else if (bus.op == MTHI) begin
                            hi_q <= bus.rs;
                        end else if (bus.op == MTLO) begin
                            lo_q <= bus.rs;
                        end
                    end
                end
                CALC: begin
                    if (bus.cancel) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        acc <= acc_nxt;
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= FIX;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FIX: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    if (!bus.cancel) begin
                        done_q <= 1'b1;
                        if (!is_div_q) begin
                            hi_q <= prod[2*WIDTH-1:WIDTH];
                            lo_q <= prod[WIDTH-1:0];
                        end else if (dz_q) begin
                            hi_q <= rs_q;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem;
                            lo_q <= quot;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit (WIDTH=32). Expected {hi,lo} pairs are
// queued when an operation is started and compared when done is observed.
module tb_muldiv_unit;
    import mips_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [2*W-1:0] sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives start for one cycle and returns at the negedge of the
    // done cycle (or after a timeout), so a following call starts in the done cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo);
        int n;
        int busy_cycles;
        logic [2*W-1:0] exp;
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs    = a;
        bus.rt    = b;
        sb.push_back({exp_hi, exp_lo});
        @(negedge clk);
        bus.start = 1'b0;
        bus.rs    = '0;
        bus.rt    = '0;
        chk({tag, "_done_low_t1"}, 64'(bus.done), 64'd0);
        n = 1;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            if (bus.busy === 1'b1) busy_cycles++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(W + 2));
        chk({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(W + 1));
        chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        exp = sb.pop_front();
        chk({tag, "_hi"}, 64'(bus.hi), 64'(exp[2*W-1:W]));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(exp[W-1:0]));
    endtask

    initial begin
        int dones;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.rs     = '0;
        bus.rt     = '0;
        bus.cancel = 1'b0;

        // Reset
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);

        // Multiply and divide, back-to-back (each new start lands in the done cycle)
        run_op("mult_neg", MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_m1", MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
        run_op("div_neg", DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_zero", DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
        run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("divu_plain", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        @(negedge clk);
        chk("done_one_cycle", 64'(bus.done), 64'd0);

        // MTLO: single cycle, no busy
        bus.start = 1'b1;
        bus.op    = MTLO;
        bus.rs    = 32'h12345678;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mtlo_lo", 64'(bus.lo), 64'h12345678);
        chk("mtlo_hi_kept", 64'(bus.hi), 64'd2);
        chk("mtlo_busy", 64'(bus.busy), 64'd0);
        chk("mtlo_done", 64'(bus.done), 64'd0);

        // MULT with an ignored MTHI at T+5 and a cancel at T+10
        bus.start = 1'b1;
        bus.op    = MULT;
        bus.rs    = 32'd3;
        bus.rt    = 32'd4;
        @(negedge clk);                      // T+1
        bus.start = 1'b0;
        chk("cxl_busy_t1", 64'(bus.busy), 64'd1);
        repeat (4) @(negedge clk);           // T+5
        bus.start = 1'b1;
        bus.op    = MTHI;
        bus.rs    = 32'hDEADBEEF;
        @(negedge clk);                      // T+6
        bus.start = 1'b0;
        chk("busy_start_ignored_hi", 64'(bus.hi), 64'd2);
        repeat (4) @(negedge clk);           // T+10
        bus.cancel = 1'b1;
        @(negedge clk);                      // T+11
        bus.cancel = 1'b0;
        chk("cxl_busy", 64'(bus.busy), 64'd0);
        chk("cxl_hi", 64'(bus.hi), 64'd2);
        chk("cxl_lo", 64'(bus.lo), 64'h12345678);
        dones = 0;
        repeat (40) begin
            if (bus.done === 1'b1) dones++;
            @(negedge clk);
        end
        chk("cxl_no_done", 64'(dones), 64'd0);
        chk("cxl_lo_later", 64'(bus.lo), 64'h12345678);

        // Cancel in IDLE blocks a same-cycle start
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        bus.op     = MTLO;
        bus.rs     = 32'h0BADF00D;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        chk("idle_cancel_lo", 64'(bus.lo), 64'h12345678);

        // No-op code leaves everything alone
        bus.start = 1'b1;
        bus.op    = 3'd6;
        bus.rs    = 32'hCAFEF00D;
        @(negedge clk);
        bus.start = 1'b0;
        chk("noop_busy", 64'(bus.busy), 64'd0);
        chk("noop_lo", 64'(bus.lo), 64'h12345678);
        chk("noop_hi", 64'(bus.hi), 64'd2);

        // Reset in the middle of a DIVU
        bus.start = 1'b1;
        bus.op    = DIVU;
        bus.rs    = 32'd1000;
        bus.rt    = 32'd3;
        @(negedge clk);                      // T+1
        bus.start = 1'b0;
        repeat (19) @(negedge clk);          // T+20
        reset = 1'b1;
        @(negedge clk);                      // T+21
        reset = 1'b0;
        chk("mid_rst_hi", 64'(bus.hi), 64'd0);
        chk("mid_rst_lo", 64'(bus.lo), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_done", 64'(bus.done), 64'd0);
        run_op("multu_after_rst", MULTU, 32'd3, 32'd4, 32'd0, 32'h0000000C);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
